// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-memory write bus
// for imem_loader.
//   Control   : start, base_addr, word_count, abort       (master -> slave)
//   Stream    : byte_valid, byte_data -> ; <- byte_ready
//   Mem write : mem_we, mem_addr, mem_wdata               (slave -> master)
//   Status    : word_out, word_valid, busy, done, wrap_err (slave -> master)
//   Optional  : checksum when IMEM_LOADER_CHECKSUM_EN is defined
interface imem_loader_if #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 6
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [31:0]       word_out;
    logic              word_valid;
    logic              busy;
    logic              done;
    logic              wrap_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    modport slave (
        input  start, base_addr, word_count, abort, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, word_out, word_valid,
               busy, done, wrap_err
`ifdef IMEM_LOADER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output start, base_addr, word_count, abort, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, word_out, word_valid,
               busy, done, wrap_err
`ifdef IMEM_LOADER_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writes a big-endian byte stream into byte-wide instruction
// memory starting at a word-aligned base, holding the fetch stage (busy)
// while loading and reporting each assembled 32-bit word.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - imem_loader_if.slave (control, byte stream, memory write, status)
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add bus.checksum, the
// XOR of all words assembled since the last accepted start.
module imem_loader #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 7,
    parameter int CNT_W     = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_MAX  = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W-1:0]  ALIGN_MSK = ~ADDR_W'(3);
    localparam logic [CNT_W+1:0]   CNT_ONE   = (CNT_W+2)'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W+1:0]  r_cnt;
    logic [CNT_W+1:0]  r_total;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic [23:0]       r_asm;
    logic [31:0]       r_word;
    logic              r_word_valid;
    logic              r_wrap_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       r_checksum;
`endif

    logic              w_start_ok;
    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic [CNT_W+1:0]  w_cnt_nxt;
    logic [31:0]       w_full_word;

    assign w_cnt_nxt   = r_cnt + CNT_ONE;
    assign w_full_word = {r_asm, bus.byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // abort withdraws byte_ready so a byte offered alongside it is never taken
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_ready    = 1'b0;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.word_count != '0)) begin
                    w_start_ok = 1'b1;
                    w_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready  = !bus.abort;
                w_accept = bus.byte_valid && w_ready;
                w_last   = w_accept && (w_cnt_nxt == r_total);
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_total      <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_asm        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_wrap_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_we         <= w_accept;
            r_word_valid <= 1'b0;
            if (w_start_ok) begin
                r_addr     <= bus.base_addr & ALIGN_MSK;
                r_total    <= {bus.word_count, 2'b00};
                r_cnt      <= '0;
                r_wrap_err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_checksum <= '0;
`endif
            end
            if (w_accept) begin
                r_waddr <= r_addr;
                r_wdata <= bus.byte_data;
                r_addr  <= r_addr + ADDR_ONE;
                r_cnt   <= w_cnt_nxt;
                // the next byte would land at address 0
                if ((r_addr == ADDR_MAX) && !w_last) begin
                    r_wrap_err <= 1'b1;
                end
                case (r_cnt[1:0])
                    2'd0: r_asm[23:16] <= bus.byte_data;
                    2'd1: r_asm[15:8]  <= bus.byte_data;
                    2'd2: r_asm[7:0]   <= bus.byte_data;
                    default: begin
                        r_word       <= w_full_word;
                        r_word_valid <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_checksum   <= r_checksum ^ w_full_word;
`endif
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_waddr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.word_out   = r_word;
    assign bus.word_valid = r_word_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.wrap_err   = r_wrap_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. A negedge monitor logs
// memory writes, accepted bytes, assembled words and done pulses; the main
// sequence compares those logs against hand-computed expectations.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader_if #(.ADDR_W(7), .CNT_W(6)) bus ();

    imem_loader #(.MEM_BYTES(128), .ADDR_W(7), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0]  wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];
    int          ac_q[$];
    logic [31:0] wo_q[$];
    int          done_cnt = 0;
    logic [7:0]  done_addr = 8'hFF;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cks_at_done = '0;
`endif

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            wc_q.push_back(cyc);
        end
        if (bus.byte_valid && bus.byte_ready && !bus.abort) ac_q.push_back(cyc);
        if (bus.word_valid) wo_q.push_back(bus.word_out);
        if (bus.done) begin
            done_cnt  = done_cnt + 1;
            done_addr = bus.mem_we ? {1'b0, bus.mem_addr} : 8'hFF;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cks_at_done = bus.checksum;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] vec [0:7];
    int b_w, b_a, b_o, b_d;

    task automatic mark();
        b_w = wa_q.size();
        b_a = ac_q.size();
        b_o = wo_q.size();
        b_d = done_cnt;
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic do_start(input logic [6:0] base, input logic [5:0] wc);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = wc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        bit ok;
        int n;
        if (stall) begin
            bus.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = bus.byte_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) check("byte_ready_timeout", 32'd0, 32'd1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic load(input logic [6:0] base, input logic [5:0] wc, input int nb, input bit stall);
        mark();
        do_start(base, wc);
        for (int i = 0; i < nb; i++) send(vec[i], stall);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_writes(input string tag, input int a0, input int n);
        check({tag, "_nwr"}, wa_q.size() - b_w, n);
        if (wa_q.size() - b_w == n) begin
            for (int i = 0; i < n; i++) begin
                check({tag, "_addr"}, wa_q[b_w + i], (a0 + i) % 128);
                check({tag, "_data"}, wd_q[b_w + i], vec[i]);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.abort = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;

        // Reset state
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_word", bus.word_out, 0);
        check("rst_wrap", bus.wrap_err, 0);
        check("rst_ready", bus.byte_ready, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // word_count=0 is ignored
        mark();
        do_start(7'd8, 6'd0);
        check("wc0_busy", bus.busy, 0);
        idle_cycles(3);
        check("wc0_done", done_cnt - b_d, 0);
        check("wc0_nwr", wa_q.size() - b_w, 0);

        // Basic load
        vec = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
        load(7'd8, 6'd2, 8, 1'b0);
        idle_cycles(3);
        chk_writes("basic", 8, 8);
        check("basic_nwords", wo_q.size() - b_o, 2);
        if (wo_q.size() - b_o == 2) begin
            check("basic_word0", wo_q[b_o], 32'h20080005);
            check("basic_word1", wo_q[b_o + 1], 32'hAC090004);
        end
        check("basic_done", done_cnt - b_d, 1);
        check("basic_done_with_last_we", done_addr, 8'd15);
        check("basic_latency", wc_q[b_w] - ac_q[b_a], 1);
        check("basic_wrap", bus.wrap_err, 0);
        check("basic_idle", bus.busy, 0);

        // Stalls and alignment
        vec = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        load(7'd6, 6'd1, 4, 1'b1);
        idle_cycles(3);
        chk_writes("stall", 4, 4);
        if (ac_q.size() - b_a == 4 && wc_q.size() - b_w == 4) begin
            for (int i = 0; i < 4; i++)
                check("stall_wr_on_hs", wc_q[b_w + i] - ac_q[b_a + i], 1);
        end else begin
            check("stall_naccept", ac_q.size() - b_a, 4);
        end
        check("stall_word", bus.word_out, 32'h01020304);
        check("stall_done", done_cnt - b_d, 1);

        // Wrap past the top of memory
        vec = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        load(7'd124, 6'd2, 8, 1'b0);
        idle_cycles(3);
        chk_writes("wrap", 124, 8);
        check("wrap_err_set", bus.wrap_err, 1);
        check("wrap_done", done_cnt - b_d, 1);

        // Next start clears wrap_err; also the checksum vector pair
        vec = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        mark();
        do_start(7'd0, 6'd2);
        check("wrap_err_cleared", bus.wrap_err, 0);
        for (int i = 0; i < 8; i++) send(vec[i], 1'b0);
        idle_cycles(3);
        chk_writes("cks_load", 0, 8);
        check("cks_load_done", done_cnt - b_d, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("checksum_at_done", cks_at_done, 32'h33333333);
`endif

        // Abort after 5 bytes with a byte offered in the same cycle
        vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
        load(7'd32, 6'd4, 5, 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h66;
        bus.abort      = 1'b1;
        @(posedge clk); #1;
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
        check("abort_busy", bus.busy, 0);
        idle_cycles(3);
        chk_writes("abort", 32, 5);
        check("abort_word", bus.word_out, 32'h11223344);
        check("abort_nwords", wo_q.size() - b_o, 1);
        check("abort_done", done_cnt - b_d, 0);

        // Reset in the middle of a load
        vec = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        load(7'd64, 6'd2, 5, 1'b0);
        check("midrst_busy_before", bus.busy, 1);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_we", bus.mem_we, 0);
        check("midrst_word", bus.word_out, 0);
        check("midrst_ready", bus.byte_ready, 0);
        mark();
        idle_cycles(3);
        check("midrst_nwr", wa_q.size() - b_w, 0);
        bus.byte_valid = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);
        check("midrst_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-wide instruction memory that the fetch stage reads big-endian (MEM[a] is the MSB of the word at address a).
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into instruction memory starting at a word-aligned base.
- Holds the fetch stage while loading, and reports each assembled 32-bit word and load completion.

Parameters:
- MEM_BYTES, 128, instruction memory depth in bytes (power of two).
- ADDR_W, 7, byte address width; equals log2(MEM_BYTES).
- CNT_W, 6, width of the word count; must hold MEM_BYTES/4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load.
- base_addr  input  ADDR_W  start byte address; bits [1:0] forced to 0.
- word_count  input  CNT_W  number of 32-bit words to load.
- abort  input  1  cancel an active load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte, MSB-first per word.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory byte write enable.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  8  write data.
- word_out  output  32  last assembled word, {b0,b1,b2,b3}.
- word_valid  output  1  one-cycle pulse when word_out updates.
- busy  output  1  load in progress; fetch stage holds its PC while high.
- done  output  1  one-cycle pulse on load completion.
- wrap_err  output  1  sticky flag: the write address wrapped past MEM_BYTES-1.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including word_out=0, wrap_err=0.
  - Internal byte counter and address register 0.
- State IDLE:
  - byte_ready=0, busy=0.
  - start=1 with word_count!=0: latch addr={base_addr[ADDR_W-1:2],2'b00}, latch byte total = word_count*4, clear wrap_err, go to LOAD.
  - start with word_count=0: ignored; stay IDLE, no done.
- State LOAD:
  - busy=1, byte_ready=1.
  - Handshake on byte_valid&&byte_ready. The accepted byte is registered, so mem_we=1, mem_addr=addr, mem_wdata=byte appear the cycle after acceptance (latency 1).
  - After each accepted byte: addr increments by 1, modulo MEM_BYTES.
  - If addr wraps from MEM_BYTES-1 to 0 and more bytes remain, set wrap_err. wrap_err stays set until the next accepted start.
  - Word assembly:
    - Byte index 0 goes to word_out[31:24], index 1 to [23:16], index 2 to [15:8], index 3 to [7:0].
    - On the 4th byte, word_out updates and word_valid pulses in the same cycle as that byte's mem_we.
  - Last byte accepted: byte_ready drops the following cycle. That cycle carries the final mem_we plus done=1 pulse, then the block enters IDLE (a DONE state of one cycle).
  - start while in LOAD: ignored.
  - abort=1 in LOAD:
    - Any byte offered in that same cycle is not accepted.
    - Go to IDLE next cycle with no done. Pending writes for previously accepted bytes still complete.
    - word_out keeps its last complete word.
  - byte_valid low: no progress, no write. Stalls of any length are allowed.
- DONE (1 cycle): done=1, busy=1, byte_ready=0; then IDLE.
- Arithmetic:
  - Byte counter width CNT_W+2.
  - Address arithmetic truncated to ADDR_W bits.
- Reset mid-load: immediate IDLE. Outputs clear asynchronously, and no further writes occur.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0], cleared on reset and on accepted start.
  - checksum XORs in each assembled word on word_valid.
  - Final value is valid when done pulses.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low mid-run → all outputs 0 immediately; start=1 with word_count=0 → stays IDLE, busy=0, no done.
- Basic load: base_addr=7'd8, word_count=2, bytes 20,08,00,05,AC,09,00,04 back-to-back → mem_we at addresses 8..15 in order, word_valid with word_out=32'h20080005 then 32'hAC090004, done one cycle after the last mem_we cycle minus zero (same cycle), wrap_err=0.
- Stalls and alignment: base_addr=7'd6, word_count=1, byte_valid toggled every other cycle → writes to addresses 4..7 only on handshake cycles, 4 writes total, done once.
- Wrap: base_addr=7'd124, word_count=2 → writes to 124..127 then 0..3, wrap_err=1 after the write to 0; next start clears it.
- Abort: word_count=4, abort asserted after 5 bytes with a byte offered in the same cycle → exactly 5 mem_we, word_out=first word, no done, busy=0 next cycle.
- Checksum (IMEM_LOADER_CHECKSUM_EN): words 32'h11111111, 32'h22222222 → checksum=32'h33333333 at done.
